ball_frame_sync: RTL and testbench

- Display-side counterpart of the processor's ball registers.
- Generates the raster counters and the once-per-frame screenEnd strobe that paces game software.
- Samples the processor's ball_x/ball_y once per frame into tear-free shadow registers.
- Computes the bounce directions ball_xdir/ball_ydir from wall and paddle collisions, and flags the pixels covered by the ball.

---
 rtl/ball_frame_sync.sv | 217 +++++++++++++++++++++
 tb/tb_ball_frame_sync.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_frame_sync.sv
// ball_frame_sync: raster counters, once-per-frame screenEnd, tear-free ball shadows and bounce logic.
// Optional BALL_FRAME_SYNC_SCORE_EN adds the miss strobes and saturating score counters.
module ball_frame_sync #(
    parameter int H_VISIBLE  = 640,
    parameter int H_TOTAL    = 800,
    parameter int V_VISIBLE  = 480,
    parameter int V_TOTAL    = 525,
    parameter int BALL_SIZE  = 8,
    parameter int PADDLE_L_X = 16,
    parameter int PADDLE_R_X = 624
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [31:0] ball_x,
    input  logic [31:0] ball_y,
    input  logic [8:0]  padL_top,
    input  logic [8:0]  padL_bot,
    input  logic [8:0]  padR_top,
    input  logic [8:0]  padR_bot,
    output logic        screenEnd,
    output logic [31:0] ball_xdir,
    output logic [31:0] ball_ydir,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        visible,
    output logic        ball_pixel,
    output logic        point_l,
    output logic        point_r,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic [1:0]  fsm_state
);

    localparam int X_MAX = H_VISIBLE - BALL_SIZE;
    localparam int Y_MAX = V_VISIBLE - BALL_SIZE;

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_PRE   = 10'(V_VISIBLE - 1);
    localparam logic [9:0]  H_VIS_V = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS_V = 10'(V_VISIBLE);
    localparam logic [9:0]  X_MAX_V = 10'(X_MAX);
    localparam logic [9:0]  Y_MAX_V = 10'(Y_MAX);
    localparam logic [9:0]  PL_X_V  = 10'(PADDLE_L_X);
    localparam logic [10:0] PR_X_V  = 11'(PADDLE_R_X);
    localparam logic [10:0] BS_W    = 11'(BALL_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_EVAL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        arm_q, arm_d;
    logic [9:0]  shadow_x_q, shadow_x_d;
    logic [9:0]  shadow_y_q, shadow_y_d;
    logic        xneg_q, xneg_d;
    logic        yneg_q, yneg_d;
    logic        ball_pixel_q, ball_pixel_d;

    logic [10:0] x_ext, y_ext, y_low_edge, h_ext, v_ext;
    logic        l_zone, r_zone, l_cover, r_cover;
    logic        at_x0, at_xmax;
    logic        in_x, in_y, vis;

    // Negative coordinates pin to 0, anything past the last legal position pins to it.
    function automatic logic [9:0] clamp(input logic [31:0] v, input logic [9:0] maxv);
        logic [9:0] r;
        if (v[31])
            r = '0;
        else if (v > {22'd0, maxv})
            r = maxv;
        else
            r = v[9:0];
        return r;
    endfunction

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    // arm fires on the step that lands on (0, V_VISIBLE); the FSM turns it into screenEnd one clock later.
    assign arm_d = pix_en && (hcount_q == H_LAST) && (vcount_q == V_PRE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arm_q) state_d = S_LATCH;
            S_LATCH: state_d = S_EVAL;
            S_EVAL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign x_ext      = {1'b0, shadow_x_q};
    assign y_ext      = {1'b0, shadow_y_q};
    assign y_low_edge = y_ext + BS_W - 11'd1;
    assign l_zone     = shadow_x_q <= PL_X_V;
    assign r_zone     = (x_ext + BS_W) >= PR_X_V;
    assign l_cover    = (y_low_edge >= {2'b00, padL_top}) && (y_ext <= {2'b00, padL_bot});
    assign r_cover    = (y_low_edge >= {2'b00, padR_top}) && (y_ext <= {2'b00, padR_bot});
    assign at_x0      = shadow_x_q == '0;
    assign at_xmax    = shadow_x_q == X_MAX_V;

    always_comb begin
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        xneg_d     = xneg_q;
        yneg_d     = yneg_q;
        if (state_q == S_LATCH) begin
            shadow_x_d = clamp(ball_x, X_MAX_V);
            shadow_y_d = clamp(ball_y, Y_MAX_V);
        end
        if (state_q == S_EVAL) begin
            if (yneg_q && shadow_y_q == '0)
                yneg_d = 1'b0;
            else if (!yneg_q && shadow_y_q == Y_MAX_V)
                yneg_d = 1'b1;
            // A paddle hit and a wall miss both send the ball back; only the score differs.
            if (xneg_q && l_zone && (l_cover || at_x0))
                xneg_d = 1'b0;
            if (!xneg_q && r_zone && (r_cover || at_xmax))
                xneg_d = 1'b1;
        end
    end

    assign h_ext = {1'b0, hcount_q};
    assign v_ext = {1'b0, vcount_q};
    assign vis   = (hcount_q < H_VIS_V) && (vcount_q < V_VIS_V);
    assign in_x  = (h_ext >= x_ext) && (h_ext < x_ext + BS_W);
    assign in_y  = (v_ext >= y_ext) && (v_ext < y_ext + BS_W);

    assign ball_pixel_d = pix_en ? (vis && in_x && in_y) : ball_pixel_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            hcount_q     <= '0;
            vcount_q     <= '0;
            arm_q        <= 1'b0;
            shadow_x_q   <= '0;
            shadow_y_q   <= '0;
            xneg_q       <= 1'b0;
            yneg_q       <= 1'b0;
            ball_pixel_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            arm_q        <= arm_d;
            shadow_x_q   <= shadow_x_d;
            shadow_y_q   <= shadow_y_d;
            xneg_q       <= xneg_d;
            yneg_q       <= yneg_d;
            ball_pixel_q <= ball_pixel_d;
        end
    end

`ifdef BALL_FRAME_SYNC_SCORE_EN
    logic       miss_l, miss_r;
    logic       point_l_q, point_r_q;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;

    assign miss_r    = (state_q == S_EVAL) && xneg_q && l_zone && !l_cover && at_x0;
    assign miss_l    = (state_q == S_EVAL) && !xneg_q && r_zone && !r_cover && at_xmax;
    assign score_l_d = (miss_l && score_l_q != 4'hF) ? score_l_q + 4'd1 : score_l_q;
    assign score_r_d = (miss_r && score_r_q != 4'hF) ? score_r_q + 4'd1 : score_r_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            point_l_q <= 1'b0;
            point_r_q <= 1'b0;
            score_l_q <= '0;
            score_r_q <= '0;
        end else begin
            point_l_q <= miss_l;
            point_r_q <= miss_r;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
        end
    end

    assign point_l = point_l_q;
    assign point_r = point_r_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;
`else
    assign point_l = 1'b0;
    assign point_r = 1'b0;
    assign score_l = 4'd0;
    assign score_r = 4'd0;
`endif

    assign screenEnd  = (state_q == S_LATCH);
    assign ball_xdir  = xneg_q ? 32'hFFFF_FFFF : 32'h0000_0001;
    assign ball_ydir  = yneg_q ? 32'hFFFF_FFFF : 32'h0000_0001;
    assign hcount     = hcount_q;
    assign vcount     = vcount_q;
    assign visible    = vis;
    assign ball_pixel = ball_pixel_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_ball_frame_sync.sv
// Bench for ball_frame_sync on a shrunken raster so whole frames fit in a short run.
// Expectations come from a frame-level model of the bounce/score rules and a pixel-index raster model.
module tb_ball_frame_sync;

    localparam int HV = 32, HT = 36, VV = 20, VT = 22;
    localparam int BS = 4, PLX = 4, PRX = 24;
    localparam int XMAX = HV - BS, YMAX = VV - BS, FRAME = HT * VT;
`ifdef BALL_FRAME_SYNC_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    logic        clock, reset, pix_en;
    logic [31:0] ball_x, ball_y;
    logic [8:0]  padL_top, padL_bot, padR_top, padR_bot;
    logic        screenEnd, visible, ball_pixel, point_l, point_r;
    logic [31:0] ball_xdir, ball_ydir;
    logic [9:0]  hcount, vcount;
    logic [3:0]  score_l, score_r;
    logic [1:0]  fsm_state;

    ball_frame_sync #(
        .H_VISIBLE(HV), .H_TOTAL(HT), .V_VISIBLE(VV), .V_TOTAL(VT),
        .BALL_SIZE(BS), .PADDLE_L_X(PLX), .PADDLE_R_X(PRX)
    ) dut (
        .clock(clock), .reset(reset), .pix_en(pix_en),
        .ball_x(ball_x), .ball_y(ball_y),
        .padL_top(padL_top), .padL_bot(padL_bot),
        .padR_top(padR_top), .padR_bot(padR_bot),
        .screenEnd(screenEnd), .ball_xdir(ball_xdir), .ball_ydir(ball_ydir),
        .hcount(hcount), .vcount(vcount), .visible(visible), .ball_pixel(ball_pixel),
        .point_l(point_l), .point_r(point_r), .score_l(score_l), .score_r(score_r),
        .fsm_state(fsm_state)
    );

    int checks = 0, failures = 0;
    int n = 0;                 // pix_en steps since reset release: the raster position model
    int cyc = 0, pe_div = 1;
    int se_cnt = 0, se_wide = 0;
    bit prev_se = 0;

    int m_xdir = 1, m_ydir = 1, m_sl = 0, m_sr = 0, m_X = 0, m_Y = 0;
    bit e_pl, e_pr;

    logic [31:0] o_xdir1, o_ydir1, o_xdir, o_ydir;
    logic        o_pl, o_pr, o_pl2, o_pr2;
    logic [3:0]  o_sl, o_sr;

    // ---------------- clock / reset / pixel enable ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        pix_en = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            pix_en = (cyc % pe_div == 0);
        end
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) n = 0;
        else if (pix_en) n = n + 1;
    end

    always @(negedge clock) begin
        if (screenEnd === 1'b1) begin
            se_cnt++;
            if (prev_se) se_wide++;
        end
        prev_se = (screenEnd === 1'b1);
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int clampi(int v, int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    function automatic logic [31:0] dir32(int d);
        return (d < 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
    endfunction

    function automatic bit exp_pix(int nn);
        int h = nn % HT;
        int v = (nn / HT) % VT;
        return (h < HV) && (v < VV) && (h >= m_X) && (h < m_X + BS) && (v >= m_Y) && (v < m_Y + BS);
    endfunction

    task automatic model_frame(input int bx, by, lt, lb, rt, rb);
        int nx, ny;
        m_X = clampi(bx, XMAX);
        m_Y = clampi(by, YMAX);
        nx = m_xdir; ny = m_ydir; e_pl = 0; e_pr = 0;
        if (m_Y == 0 && m_ydir < 0) ny = 1;
        if (m_Y == YMAX && m_ydir > 0) ny = -1;
        if (m_xdir < 0 && m_X <= PLX) begin
            if (m_Y + BS - 1 >= lt && m_Y <= lb) nx = 1;
            else if (m_X == 0) begin nx = 1; e_pr = SCORE_EN; end
        end
        if (m_xdir > 0 && m_X + BS >= PRX) begin
            if (m_Y + BS - 1 >= rt && m_Y <= rb) nx = -1;
            else if (m_X == XMAX) begin nx = -1; e_pl = SCORE_EN; end
        end
        if (e_pl && m_sl < 15) m_sl++;
        if (e_pr && m_sr < 15) m_sr++;
        m_xdir = nx;
        m_ydir = ny;
    endtask

    // ---------------- drivers ----------------
    task automatic wait_se(output bit ok);
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if (screenEnd === 1'b1) begin ok = 1; break; end
        end
    endtask

    // Presents one frame of processor state, then samples at T+1, T+2 and T+3.
    task automatic run_frame(input int bx, by, lt, lb, rt, rb);
        bit ok;
        ball_x = 32'(bx); ball_y = 32'(by);
        padL_top = 9'(lt); padL_bot = 9'(lb); padR_top = 9'(rt); padR_bot = 9'(rb);
        wait_se(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL frame_timeout: screenEnd got 0 required 1 within 4000 clocks"); end
        model_frame(bx, by, lt, lb, rt, rb);
        @(negedge clock); o_xdir1 = ball_xdir; o_ydir1 = ball_ydir;
        @(negedge clock); o_xdir = ball_xdir; o_ydir = ball_ydir;
        o_pl = point_l; o_pr = point_r; o_sl = score_l; o_sr = score_r;
        @(negedge clock); o_pl2 = point_l; o_pr2 = point_r;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (hcount !== 10'd0 || vcount !== 10'd0) begin failures++; $display("FAIL reset_counters: got %0d,%0d required 0,0", hcount, vcount); end
        checks++; if (screenEnd !== 1'b0) begin failures++; $display("FAIL reset_screenEnd: got %b required 0", screenEnd); end
        checks++; if (ball_xdir !== 32'h1 || ball_ydir !== 32'h1) begin failures++; $display("FAIL reset_dirs: got %h,%h required 1,1", ball_xdir, ball_ydir); end
        checks++; if (ball_pixel !== 1'b0 || point_l !== 1'b0 || point_r !== 1'b0) begin failures++; $display("FAIL reset_strobes: got pix=%b pl=%b pr=%b required 0", ball_pixel, point_l, point_r); end
        checks++; if (score_l !== 4'd0 || score_r !== 4'd0) begin failures++; $display("FAIL reset_scores: got %0d,%0d required 0,0", score_l, score_r); end
        checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_fsm: got %0d required 0", fsm_state); end
        checks++; if (visible !== 1'b1) begin failures++; $display("FAIL reset_visible: got %b required 1", visible); end
    endtask

    task automatic test_counters();
        bit ok1, ok2;
        int n1, n2, c0;
        pe_div = 4;
        ball_x = 32'd10; ball_y = 32'd8;
        padL_top = 9'd0; padL_bot = 9'd0; padR_top = 9'd0; padR_bot = 9'd0;
        c0 = se_cnt;
        reset = 1'b1;
        wait_se(ok1); n1 = n;
        checks++; if (!ok1) begin failures++; $display("FAIL cnt_first_pulse: seen %b required 1", ok1); end
        checks++; if (hcount !== 10'd0 || vcount !== 10'(VV)) begin failures++; $display("FAIL cnt_pulse_pos: got %0d,%0d required 0,%0d", hcount, vcount, VV); end
        checks++; if (n1 % FRAME != VV * HT) begin failures++; $display("FAIL cnt_pulse_step: got %0d required %0d", n1 % FRAME, VV * HT); end
        @(negedge clock);
        checks++; if (screenEnd !== 1'b0) begin failures++; $display("FAIL cnt_pulse_width: got %b required 0", screenEnd); end
        wait_se(ok2); n2 = n;
        checks++; if (!ok2 || n2 - n1 != FRAME) begin failures++; $display("FAIL cnt_spacing: got %0d required %0d", n2 - n1, FRAME); end
        repeat (2) @(negedge clock);
        checks++; if (se_cnt - c0 != 2 || se_wide != 0) begin failures++; $display("FAIL cnt_pulses: got %0d wide=%0d required 2 wide=0", se_cnt - c0, se_wide); end
        checks++; if (hcount !== 10'(n % HT) || vcount !== 10'((n / HT) % VT)) begin failures++; $display("FAIL cnt_raster: got %0d,%0d required %0d,%0d", hcount, vcount, n % HT, (n / HT) % VT); end
        pe_div = 1;
    endtask

    task automatic test_walls();
        run_frame(10, YMAX, 0, 0, 0, 0);
        checks++; if (o_ydir1 !== 32'h1) begin failures++; $display("FAIL bottom_early: got %h required 00000001", o_ydir1); end
        checks++; if (o_ydir !== 32'hFFFF_FFFF) begin failures++; $display("FAIL bottom_ydir: got %h required ffffffff", o_ydir); end
        checks++; if (o_xdir !== 32'h1) begin failures++; $display("FAIL bottom_xdir: got %h required 00000001", o_xdir); end
        run_frame(10, -3, 0, 0, 0, 0);
        checks++; if (o_ydir !== 32'h1) begin failures++; $display("FAIL top_ydir: got %h required 00000001", o_ydir); end
    endtask

    task automatic test_left_hit();
        run_frame(XMAX, 8, 0, 0, 0, 100);
        checks++; if (o_xdir !== 32'hFFFF_FFFF) begin failures++; $display("FAIL right_hit_xdir: got %h required ffffffff", o_xdir); end
        run_frame(2, 8, 12, 30, 0, 0);
        checks++; if (o_xdir !== 32'hFFFF_FFFF || o_pr !== 1'b0) begin failures++; $display("FAIL left_edge_nohit: got %h pr=%b required ffffffff pr=0", o_xdir, o_pr); end
        run_frame(2, 8, 11, 30, 0, 0);
        checks++; if (o_xdir !== 32'h1 || o_pr !== 1'b0) begin failures++; $display("FAIL left_hit: got %h pr=%b required 00000001 pr=0", o_xdir, o_pr); end
    endtask

    task automatic test_left_miss();
        run_frame(XMAX, 10, 0, 0, 0, 100);
        run_frame(0, 10, 0, 5, 0, 0);
        checks++; if (o_xdir !== 32'h1) begin failures++; $display("FAIL miss_xdir: got %h required 00000001", o_xdir); end
        checks++; if (o_pr !== SCORE_EN || o_pr2 !== 1'b0 || o_pl !== 1'b0) begin failures++; $display("FAIL miss_point_r: got %b,%b pl=%b required %b,0 pl=0", o_pr, o_pr2, o_pl, SCORE_EN); end
        checks++; if (o_sr !== 4'(SCORE_EN ? 1 : 0)) begin failures++; $display("FAIL miss_score_r: got %0d required %0d", o_sr, SCORE_EN ? 1 : 0); end
        for (int i = 0; i < 19; i++) begin
            run_frame(XMAX, 10, 0, 0, 0, 100);
            run_frame(0, 10, 0, 5, 0, 0);
        end
        checks++; if (o_sr !== 4'(SCORE_EN ? 15 : 0) || o_sr !== 4'(m_sr)) begin failures++; $display("FAIL miss_saturate: got %0d required %0d", o_sr, SCORE_EN ? 15 : 0); end
    endtask

    task automatic test_right_miss();
        run_frame(XMAX + 50, 5, 0, 0, 15, 20);
        checks++; if (o_xdir !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rmiss_xdir: got %h required ffffffff", o_xdir); end
        checks++; if (o_pl !== SCORE_EN || o_pl2 !== 1'b0 || o_pr !== 1'b0) begin failures++; $display("FAIL rmiss_point_l: got %b,%b pr=%b required %b,0 pr=0", o_pl, o_pl2, o_pr, SCORE_EN); end
        checks++; if (o_sl !== 4'(SCORE_EN ? 1 : 0)) begin failures++; $display("FAIL rmiss_score_l: got %0d required %0d", o_sl, SCORE_EN ? 1 : 0); end
    endtask

    task automatic test_corner();
        run_frame(0, YMAX, 0, 2, 0, 0);
        checks++; if (o_xdir !== 32'h1 || o_ydir !== 32'hFFFF_FFFF) begin failures++; $display("FAIL corner_dirs: got %h,%h required 00000001,ffffffff", o_xdir, o_ydir); end
        checks++; if (o_pr !== SCORE_EN || o_sr !== 4'(SCORE_EN ? 15 : 0)) begin failures++; $display("FAIL corner_score: got pr=%b sr=%0d required pr=%b sr=%0d", o_pr, o_sr, SCORE_EN, SCORE_EN ? 15 : 0); end
    endtask

    task automatic test_clamp_pixel();
        int prev_n, hits, bad, rbad;
        run_frame(-5, 1000, 0, 0, 0, 0);
        checks++; if (m_X != 0 || m_Y != YMAX) begin failures++; $display("FAIL clamp_model: got %0d,%0d required 0,%0d", m_X, m_Y, YMAX); end
        hits = 0; bad = 0; rbad = 0; prev_n = n;
        for (int i = 0; i < FRAME + 4; i++) begin
            @(negedge clock);
            if (ball_pixel !== exp_pix(prev_n)) bad++;
            if (ball_pixel === 1'b1) hits++;
            if (hcount !== 10'(n % HT) || vcount !== 10'((n / HT) % VT) ||
                visible !== ((n % HT) < HV && ((n / HT) % VT) < VV)) rbad++;
            prev_n = n;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL pixel_map: got %0d wrong pixels required 0", bad); end
        checks++; if (hits != BS * BS) begin failures++; $display("FAIL pixel_count: got %0d required %0d", hits, BS * BS); end
        checks++; if (rbad != 0) begin failures++; $display("FAIL raster_track: got %0d wrong samples required 0", rbad); end
    endtask

    task automatic test_random();
        int bx, by, lt, lb, rt, rb;
        for (int f = 0; f < 16; f++) begin
            bx = rnd_coord(XMAX); by = rnd_coord(YMAX);
            lt = $urandom_range(0, VV); lb = lt + int'($urandom_range(0, 10));
            rt = $urandom_range(0, VV); rb = rt + int'($urandom_range(0, 10));
            run_frame(bx, by, lt, lb, rt, rb);
            checks++; if (o_xdir !== dir32(m_xdir) || o_ydir !== dir32(m_ydir)) begin failures++; $display("FAIL rand_dirs f%0d: got %h,%h required %h,%h", f, o_xdir, o_ydir, dir32(m_xdir), dir32(m_ydir)); end
            checks++; if (o_pl !== e_pl || o_pr !== e_pr || o_pl2 !== 1'b0 || o_pr2 !== 1'b0) begin failures++; $display("FAIL rand_points f%0d: got %b%b%b%b required %b%b00", f, o_pl, o_pr, o_pl2, o_pr2, e_pl, e_pr); end
            checks++; if (o_sl !== 4'(m_sl) || o_sr !== 4'(m_sr)) begin failures++; $display("FAIL rand_scores f%0d: got %0d,%0d required %0d,%0d", f, o_sl, o_sr, m_sl, m_sr); end
        end
    endtask

    function automatic int rnd_coord(int mx);
        int s = $urandom_range(0, 4);
        case (s)
            0: return -int'($urandom_range(1, 40));
            1: return mx + int'($urandom_range(0, 40));
            2: return 0;
            3: return int'($urandom_range(0, PLX));
            default: return int'($urandom_range(0, mx));
        endcase
    endfunction

    task automatic test_async_reset();
        bit ok;
        run_frame(XMAX, 8, 0, 0, 0, 100);
        wait_se(ok);
        @(negedge clock);
        checks++; if (!ok || fsm_state !== 2'd2) begin failures++; $display("FAIL ar_in_eval: got state %0d required 2", fsm_state); end
        #1 reset = 1'b0;
        #1;
        checks++; if (ball_xdir !== 32'h1 || ball_ydir !== 32'h1) begin failures++; $display("FAIL ar_dirs: got %h,%h required 1,1", ball_xdir, ball_ydir); end
        checks++; if (score_l !== 4'd0 || score_r !== 4'd0 || screenEnd !== 1'b0) begin failures++; $display("FAIL ar_scores: got %0d,%0d se=%b required 0,0 se=0", score_l, score_r, screenEnd); end
        checks++; if (hcount !== 10'd0 || vcount !== 10'd0 || fsm_state !== 2'd0) begin failures++; $display("FAIL ar_state: got %0d,%0d st=%0d required 0,0 st=0", hcount, vcount, fsm_state); end
        m_xdir = 1; m_ydir = 1; m_sl = 0; m_sr = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (hcount !== 10'd0) begin failures++; $display("FAIL ar_restart0: got %0d required 0", hcount); end
        @(negedge clock);
        checks++; if (hcount !== 10'd1 || vcount !== 10'd0) begin failures++; $display("FAIL ar_restart1: got %0d,%0d required 1,0", hcount, vcount); end
    endtask

    initial begin
        reset = 1'b0;
        ball_x = '0; ball_y = '0;
        padL_top = '0; padL_bot = '0; padR_top = '0; padR_bot = '0;
        test_reset();
        test_counters();
        test_walls();
        test_left_hit();
        test_left_miss();
        test_right_miss();
        test_corner();
        test_clamp_pixel();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
